// File: rtl/led_sequencer.sv
// led_sequencer: steps an 8-LED chase/bounce/fill/flash animation on each rising edge of blink_wire.
module led_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             blink_wire,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] leds,
  output logic [7:0]       step_count,
  output logic             frame_done
);
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;
  typedef enum logic [1:0] {CHASE = 2'd0, BOUNCE = 2'd1, FILL = 2'd2, FLASH = 2'd3} mode_t;
  localparam logic [WIDTH-1:0] LO  = WIDTH'(1);
  localparam logic [WIDTH-1:0] HI  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL = {WIDTH{1'b1}};
  logic [1:0]       r_mode_s1, r_mode_s2;
  logic             r_blink_q;
  mode_t            r_mode_q, w_mode_n;
  dir_t             r_dir, w_dir_n, w_dir_step;
  logic [WIDTH-1:0] r_leds, w_leds_n, w_leds_step, w_start_cur, w_start_new;
  logic [7:0]       r_cnt, w_cnt_n;
  logic             r_fd, w_fd_n;
  logic             w_step, w_change;
  assign leds       = r_leds;
  assign step_count = r_cnt;
  assign frame_done = r_fd;
  always_comb begin
    w_step      = ena & blink_wire & ~r_blink_q;
    w_change    = ena & (r_mode_s2 != r_mode_q);
    w_start_cur = r_mode_q[1] ? '0 : LO;
    w_start_new = r_mode_s2[1] ? '0 : LO;
    w_leds_step = r_mode_q == CHASE  ? {r_leds[WIDTH-2:0], r_leds[WIDTH-1]} :
                  r_mode_q == BOUNCE ? (r_dir == UP ? r_leds << 1 : r_leds >> 1) :
                  r_mode_q == FILL   ? {r_leds[WIDTH-2:0], r_dir == UP} : ~r_leds;
    w_dir_step  = r_mode_q == BOUNCE ? (w_leds_step == HI ? DOWN : w_leds_step == LO ? UP : r_dir) :
                  r_mode_q == FILL   ? (w_leds_step == ALL ? DOWN : w_leds_step == '0 ? UP : r_dir) : r_dir;
    w_mode_n    = w_change ? mode_t'(r_mode_s2) : r_mode_q;
    w_leds_n    = w_change ? w_start_new : w_step ? w_leds_step : r_leds;
    w_dir_n     = w_change ? UP : w_step ? w_dir_step : r_dir;
    w_cnt_n     = w_change ? 8'd0 : w_step ? r_cnt + 8'd1 : r_cnt;
    w_fd_n      = ~w_change & w_step & (w_leds_step == w_start_cur);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode_s1 <= '0;
      r_mode_s2 <= '0;
      r_blink_q <= 1'b0;
      r_mode_q  <= CHASE;
      r_dir     <= UP;
      r_leds    <= LO;
      r_cnt     <= '0;
      r_fd      <= 1'b0;
    end else begin
      r_mode_s1 <= mode;
      r_mode_s2 <= r_mode_s1;
      r_blink_q <= blink_wire;
      r_mode_q  <= w_mode_n;
      r_dir     <= w_dir_n;
      r_leds    <= w_leds_n;
      r_cnt     <= w_cnt_n;
      r_fd      <= w_fd_n;
    end
  end
endmodule
